// File: rtl/wb_spi_mailbox_pkg.sv
// Shared register map, STATUS bit positions and ID default for the Wishbone mailbox.
package wb_spi_mailbox_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] ID_DEFAULT = 32'h4D42_0001;

    localparam logic [7:0] OFS_ID      = 8'h00;
    localparam logic [7:0] OFS_STATUS  = 8'h04;
    localparam logic [7:0] OFS_TXDATA  = 8'h08;
    localparam logic [7:0] OFS_RXDATA  = 8'h0C;
    localparam logic [7:0] OFS_SCRATCH = 8'h10;

    localparam int unsigned ST_TX_FULL    = 0;
    localparam int unsigned ST_TX_EMPTY   = 1;
    localparam int unsigned ST_RX_FULL    = 2;
    localparam int unsigned ST_RX_EMPTY   = 3;
    localparam int unsigned ST_TX_OVF     = 4;
    localparam int unsigned ST_RX_UNF     = 5;
    localparam int unsigned ST_TX_CNT_LSB = 8;
    localparam int unsigned ST_RX_CNT_LSB = 16;
    localparam int unsigned CNT_W         = 7;

    typedef enum logic [2:0] {
        REG_ID,
        REG_STATUS,
        REG_TXDATA,
        REG_RXDATA,
        REG_SCRATCH,
        REG_NONE
    } reg_sel_e;

    // Maps a word index (byte address bits [7:2]) onto a register select.
    function automatic reg_sel_e decodeReg(input logic [5:0] idx);
        case (idx)
            OFS_ID[7:2]:      return REG_ID;
            OFS_STATUS[7:2]:  return REG_STATUS;
            OFS_TXDATA[7:2]:  return REG_TXDATA;
            OFS_RXDATA[7:2]:  return REG_RXDATA;
            OFS_SCRATCH[7:2]: return REG_SCRATCH;
            default:          return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_spi_mailbox_fifo.sv
// mbx_fifo: first-word fall-through FIFO; push when full and pop when empty are ignored.
module mbx_fifo
    import wb_spi_mailbox_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  logic [DATA_W-1:0]       i_data,
    input  logic                    i_pop,
    output logic [DATA_W-1:0]       o_data,
    output logic                    o_full,
    output logic                    o_empty,
    output logic [$clog2(DEPTH):0]  o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wrPtr;
    logic [AW-1:0]     r_rdPtr;
    logic [AW:0]       r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rdPtr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/wb_spi_mailbox.sv
// Wishbone mailbox with TX/RX stream FIFOs; define WB_SPI_MAILBOX_IRQ_EN to enable the
// registered level interrupt (otherwise irq is tied low).
module wb_spi_mailbox
    import wb_spi_mailbox_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic        wb_clk,
    input  logic        wb_rst_n,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [31:0] rx_data,
    output logic        rx_ready,
    output logic        irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic        r_ack, r_err, r_txOvf, r_rxUnf;
    logic [31:0] r_dat, r_scratch;
    logic        w_req, w_bad, w_ok, w_unused;
    logic        w_txWr, w_rxRd, w_stWr, w_scWr;
    logic        w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
    logic [CW-1:0] w_txCount, w_rxCount;
    logic [31:0] w_rxHead, w_status, w_rdData;
    reg_sel_e    w_regSel;

    assign w_unused = ^{wb_adr_i[31:8], wb_adr_i[1:0]};
    assign w_regSel = decodeReg(wb_adr_i[7:2]);
    // A new request is only taken when no termination is currently showing.
    assign w_req    = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;

    always_comb begin
        w_bad = 1'b0;
        case (w_regSel)
            REG_ID:     w_bad = wb_we_i;
            REG_RXDATA: w_bad = wb_we_i;
            REG_TXDATA: w_bad = ~wb_we_i | (wb_sel_i != 4'hF);
            REG_NONE:   w_bad = 1'b1;
            default:    w_bad = 1'b0;
        endcase
    end

    assign w_ok   = w_req & ~w_bad;
    assign w_txWr = w_ok & (w_regSel == REG_TXDATA);
    assign w_rxRd = w_ok & (w_regSel == REG_RXDATA);
    assign w_stWr = w_ok & wb_we_i & (w_regSel == REG_STATUS) & wb_sel_i[0];
    assign w_scWr = w_ok & wb_we_i & (w_regSel == REG_SCRATCH);

    mbx_fifo #(.DEPTH(DEPTH)) u_txFifo (
        .clk(wb_clk), .rst_n(wb_rst_n),
        .i_push(w_txWr), .i_data(wb_dat_i), .i_pop(tx_ready),
        .o_data(tx_data), .o_full(w_txFull), .o_empty(w_txEmpty), .o_count(w_txCount)
    );

    mbx_fifo #(.DEPTH(DEPTH)) u_rxFifo (
        .clk(wb_clk), .rst_n(wb_rst_n),
        .i_push(rx_valid), .i_data(rx_data), .i_pop(w_rxRd),
        .o_data(w_rxHead), .o_full(w_rxFull), .o_empty(w_rxEmpty), .o_count(w_rxCount)
    );

    assign tx_valid = ~w_txEmpty;
    assign rx_ready = ~w_rxFull;

    always_comb begin
        w_status = '0;
        w_status[ST_TX_FULL]  = w_txFull;
        w_status[ST_TX_EMPTY] = w_txEmpty;
        w_status[ST_RX_FULL]  = w_rxFull;
        w_status[ST_RX_EMPTY] = w_rxEmpty;
        w_status[ST_TX_OVF]   = r_txOvf;
        w_status[ST_RX_UNF]   = r_rxUnf;
        w_status[ST_TX_CNT_LSB +: CNT_W] = CNT_W'(w_txCount);
        w_status[ST_RX_CNT_LSB +: CNT_W] = CNT_W'(w_rxCount);
    end

    always_comb begin
        w_rdData = '0;
        case (w_regSel)
            REG_ID:      w_rdData = ID_VALUE;
            REG_STATUS:  w_rdData = w_status;
            REG_RXDATA:  w_rdData = w_rxEmpty ? 32'h0 : w_rxHead;
            REG_SCRATCH: w_rdData = r_scratch;
            default:     w_rdData = '0;
        endcase
    end

    // Sticky flags: a set event in the same cycle takes priority over a W1C clear.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_dat     <= '0;
            r_txOvf   <= 1'b0;
            r_rxUnf   <= 1'b0;
            r_scratch <= '0;
        end else begin
            r_ack <= w_ok;
            r_err <= w_req & w_bad;
            r_dat <= (w_ok & ~wb_we_i) ? w_rdData : '0;
            if (w_txWr & w_txFull)
                r_txOvf <= 1'b1;
            else if (w_stWr & wb_dat_i[ST_TX_OVF])
                r_txOvf <= 1'b0;
            if (w_rxRd & w_rxEmpty)
                r_rxUnf <= 1'b1;
            else if (w_stWr & wb_dat_i[ST_RX_UNF])
                r_rxUnf <= 1'b0;
            if (w_scWr) begin
                for (int b = 0; b < 4; b++) begin
                    if (wb_sel_i[b]) r_scratch[8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_dat_o = r_dat;

`ifdef WB_SPI_MAILBOX_IRQ_EN
    logic r_irq;

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) r_irq <= 1'b0;
        else           r_irq <= ~w_rxEmpty | r_txOvf | r_rxUnf;
    end

    assign irq = r_irq;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_wb_spi_mailbox.sv
// Self-checking bench for wb_spi_mailbox: directed scenarios plus randomized traffic against
// a queue-based reference model (irq expectation follows WB_SPI_MAILBOX_IRQ_EN).
module tb_wb_spi_mailbox;

    localparam int DEPTH = 8;

    logic        wb_clk = 1'b0;
    logic        wb_rst_n;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o, tx_data, rx_data;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o, wb_err_o;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;

    int checks = 0;
    int errors = 0;

    logic [31:0] txQ[$];
    logic [31:0] rxQ[$];
    logic        mOvf, mUnf;
    logic [31:0] mScratch;

    wb_spi_mailbox #(.DEPTH(DEPTH)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .irq(irq)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void modelClear();
        txQ.delete();
        rxQ.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
        mScratch = '0;
    endfunction

    function automatic logic [31:0] expStatus();
        logic [31:0] s;
        s = '0;
        s[0] = (txQ.size() == DEPTH);
        s[1] = (txQ.size() == 0);
        s[2] = (rxQ.size() == DEPTH);
        s[3] = (rxQ.size() == 0);
        s[4] = mOvf;
        s[5] = mUnf;
        s[14:8]  = 7'(txQ.size());
        s[22:16] = 7'(rxQ.size());
        return s;
    endfunction

    function automatic logic expIrq();
`ifdef WB_SPI_MAILBOX_IRQ_EN
        return (rxQ.size() != 0) | mOvf | mUnf;
`else
        return 1'b0;
`endif
    endfunction

    // One clock edge of FIFO behaviour, decided from the occupancy seen before the edge.
    function automatic void modelEdge(input logic txWr, input logic [31:0] txD, input logic rxRd,
                                      output logic [31:0] rxWord, input logic txr,
                                      input logic rxv, input logic [31:0] rxd);
        bit txWasFull, txWasEmpty, rxWasFull, rxWasEmpty;
        txWasFull  = (txQ.size() == DEPTH);
        txWasEmpty = (txQ.size() == 0);
        rxWasFull  = (rxQ.size() == DEPTH);
        rxWasEmpty = (rxQ.size() == 0);
        if (txr && !txWasEmpty) void'(txQ.pop_front());
        if (txWr) begin
            if (txWasFull) mOvf = 1'b1;
            else           txQ.push_back(txD);
        end
        rxWord = '0;
        if (rxRd) begin
            if (rxWasEmpty) mUnf = 1'b1;
            else            rxWord = rxQ.pop_front();
        end
        if (rxv && !rxWasFull) rxQ.push_back(rxd);
    endfunction

    task automatic checkStreams(input string tag);
        checkOutput({tag, ".txValid"}, 32'(tx_valid), 32'(txQ.size() != 0));
        if (txQ.size() != 0) checkOutput({tag, ".txData"}, tx_data, txQ[0]);
        checkOutput({tag, ".rxReady"}, 32'(rx_ready), 32'(rxQ.size() != DEPTH));
    endtask

    // Full bus access: request at the first edge, master keeps stb up through the ack edge.
    // Starts and ends on a falling edge with all inputs idle.
    task automatic applyStimulus(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel, input logic we, input logic txr,
                                 input logic rxv, input logic [31:0] rxd, output logic [31:0] rd);
        logic [5:0]  off;
        logic        expErr;
        logic [31:0] expDat, rxWord, stat, dummy;
        off = adr[7:2];
        expErr = (off > 6'd4) || (off == 6'd0 && we) || (off == 6'd3 && we) ||
                 (off == 6'd2 && (!we || sel != 4'hF));
        stat = expStatus();
        expDat = '0;
        if (!expErr && !we) begin
            case (off)
                6'd0:    expDat = 32'h4D42_0001;
                6'd1:    expDat = stat;
                6'd4:    expDat = mScratch;
                default: expDat = '0;
            endcase
        end
        wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel; wb_we_i = we;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge wb_clk);
        modelEdge(!expErr && off == 6'd2, dat, !expErr && off == 6'd3, rxWord, txr, rxv, rxd);
        if (!expErr && !we && off == 6'd3) expDat = rxWord;
        if (!expErr && we && off == 6'd1 && sel[0]) begin
            if (dat[4]) mOvf = 1'b0;
            if (dat[5]) mUnf = 1'b0;
        end
        if (!expErr && we && off == 6'd4) begin
            for (int b = 0; b < 4; b++) if (sel[b]) mScratch[8*b +: 8] = dat[8*b +: 8];
        end
        #1;
        rd = wb_dat_o;
        checkOutput({tag, ".ack"}, 32'(wb_ack_o), 32'(!expErr));
        checkOutput({tag, ".err"}, 32'(wb_err_o), 32'(expErr));
        checkOutput({tag, ".dat"}, wb_dat_o, expDat);
        @(posedge wb_clk);
        modelEdge(1'b0, '0, 1'b0, dummy, txr, rxv, rxd);
        #1;
        checkOutput({tag, ".noSecondTerm"}, 32'(wb_ack_o | wb_err_o), 32'd0);
        checkOutput({tag, ".datIdle"}, wb_dat_o, 32'd0);
        checkStreams(tag);
        @(negedge wb_clk);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic streamCycle(input string tag, input logic txr, input logic rxv, input logic [31:0] rxd);
        logic [31:0] dummy;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge wb_clk);
        modelEdge(1'b0, '0, 1'b0, dummy, txr, rxv, rxd);
        #1;
        checkStreams(tag);
        @(negedge wb_clk);
        tx_ready = 1'b0; rx_valid = 1'b0;
    endtask

    task automatic checkIrq(input string tag);
        repeat (2) @(negedge wb_clk);
        checkOutput(tag, 32'(irq), 32'(expIrq()));
    endtask

    initial begin
        logic [31:0] rd, adr, dat;
        logic [3:0]  sel;
        int          op;

        wb_rst_n = 1'b0;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_we_i = 1'b0;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        modelClear();
        #12;
        checkOutput("reset.ack", 32'(wb_ack_o), 32'd0);
        checkOutput("reset.err", 32'(wb_err_o), 32'd0);
        checkOutput("reset.dat", wb_dat_o, 32'd0);
        checkOutput("reset.txValid", 32'(tx_valid), 32'd0);
        checkOutput("reset.rxReady", 32'(rx_ready), 32'd1);
        checkOutput("reset.irq", 32'(irq), 32'd0);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // ID and STATUS after reset
        applyStimulus("idRead", 32'h0, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("idValue", rd, 32'h4D42_0001);
        applyStimulus("statusReset", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("statusResetValue", rd, 32'h0000_000A);

        // Single TX word, then drained by the stream side
        applyStimulus("txWrite", 32'h8, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);
        checkOutput("txHeadValid", 32'(tx_valid), 32'd1);
        checkOutput("txHeadData", tx_data, 32'hDEAD_BEEF);
        applyStimulus("txCountRead", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("txCountOne", 32'(rd[14:8]), 32'd1);
        streamCycle("txDrain", 1'b1, 1'b0, '0);
        checkOutput("txEmptyAfterPop", 32'(tx_valid), 32'd0);

        // Overflow on the ninth write, then W1C clear
        for (int i = 0; i < 9; i++)
            applyStimulus("txFill", 32'h8, $urandom, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);
        applyStimulus("statusFull", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("txFullFlag", 32'(rd[0]), 32'd1);
        checkOutput("txOverflowFlag", 32'(rd[4]), 32'd1);
        checkOutput("txCountEight", 32'(rd[14:8]), 32'd8);
        checkIrq("irqOverflow");
        applyStimulus("statusW1c", 32'h4, 32'h10, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);
        applyStimulus("statusCleared", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("txOverflowCleared", 32'(rd[4]), 32'd0);
        // Write at full while the stream pops: push blocked, overflow set again
        applyStimulus("txFullPushPop", 32'h8, 32'h0BAD_F00D, 4'hF, 1'b1, 1'b1, 1'b0, '0, rd);
        for (int i = 0; i < DEPTH; i++) streamCycle("txDrainAll", 1'b1, 1'b0, '0);
        applyStimulus("statusW1cAgain", 32'h4, 32'h10, 4'h1, 1'b1, 1'b0, 1'b0, '0, rd);

        // RX underflow, then one word through the RX path
        applyStimulus("rxEmptyRead", 32'hC, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("rxEmptyData", rd, 32'd0);
        applyStimulus("statusUnderflow", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("rxUnderflowFlag", 32'(rd[5]), 32'd1);
        streamCycle("rxPush", 1'b0, 1'b1, 32'h1234_5678);
        checkIrq("irqRxData");
        applyStimulus("rxRead", 32'hC, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("rxReadData", rd, 32'h1234_5678);
        applyStimulus("statusRxEmpty", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("rxEmptyFlag", 32'(rd[3]), 32'd1);
        applyStimulus("statusW1cUnf", 32'h4, 32'h20, 4'h1, 1'b1, 1'b0, 1'b0, '0, rd);
        checkIrq("irqCleared");

        // SCRATCH byte lanes and an unmapped offset
        applyStimulus("scratchWrite", 32'h10, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, 1'b0, '0, rd);
        applyStimulus("scratchRead", 32'h10, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("scratchLanes", rd, 32'h00BB_00DD);
        applyStimulus("badOffset", 32'h20, 32'h1, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);
        applyStimulus("txPartialSel", 32'h8, 32'h55, 4'h7, 1'b1, 1'b0, 1'b0, '0, rd);
        applyStimulus("txRead", 32'h8, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        applyStimulus("idWrite", 32'h0, 32'h1, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);

        // Randomized traffic with concurrent stream activity
        for (int i = 0; i < 160; i++) begin
            op = $urandom_range(0, 5);
            dat = $urandom;
            case (op)
                0: applyStimulus("rndTxWr", 32'h8, dat, 4'hF, 1'b1, 1'($urandom), 1'($urandom), $urandom, rd);
                1: applyStimulus("rndRxRd", 32'hC, '0, 4'hF, 1'b0, 1'($urandom), 1'($urandom), $urandom, rd);
                2: applyStimulus("rndStat", 32'h4, '0, 4'hF, 1'b0, 1'($urandom), 1'($urandom), $urandom, rd);
                3: streamCycle("rndStream", 1'($urandom), 1'($urandom), dat);
                4: begin
                    sel = 4'($urandom);
                    applyStimulus("rndScratch", 32'h10, dat, sel, 1'($urandom), 1'b0, 1'($urandom), $urandom, rd);
                end
                default: begin
                    adr = $urandom;
                    adr[7:2] = 6'($urandom_range(0, 9));
                    sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                    applyStimulus("rndAny", adr, dat, sel, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, rd);
                end
            endcase
            if (i % 40 == 39) checkIrq("rndIrq");
        end

        // Reset while a read is terminating, with three TX words queued
        applyStimulus("preRstClear", 32'h4, 32'h30, 4'h1, 1'b1, 1'b0, 1'b0, '0, rd);
        for (int i = 0; i < DEPTH + 1; i++) streamCycle("preRstDrain", 1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++)
            applyStimulus("preRstFill", 32'h8, $urandom, 4'hF, 1'b1, 1'b0, 1'b0, '0, rd);
        wb_adr_i = 32'h0; wb_we_i = 1'b0; wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge wb_clk);
        #1;
        checkOutput("rstMid.ackBefore", 32'(wb_ack_o), 32'd1);
        #2 wb_rst_n = 1'b0;
        #1;
        checkOutput("rstMid.ack", 32'(wb_ack_o), 32'd0);
        checkOutput("rstMid.dat", wb_dat_o, 32'd0);
        checkOutput("rstMid.txValid", 32'(tx_valid), 32'd0);
        checkOutput("rstMid.rxReady", 32'(rx_ready), 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        modelClear();
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        applyStimulus("statusAfterRst", 32'h4, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkOutput("statusAfterRstValue", rd, 32'h0000_000A);
        applyStimulus("scratchAfterRst", 32'h10, '0, 4'hF, 1'b0, 1'b0, 1'b0, '0, rd);
        checkIrq("irqAfterRst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_spi_mailbox.md
WB_SPI_MAILBOX -- requirements
Module: wb_spi_mailbox

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO depth in 32-bit words (power of 2, 2..64).
REQ-002 SHALL have parameter ID_VALUE, default 32'h4D42_0001, value returned by the ID register.
REQ-003 SHALL have ports wb_clk (in, 1, sole clock) and wb_rst_n (in, 1, reset); one clock; reset is asynchronous and active-low.
REQ-004 SHALL have ports wb_adr_i (in, 32, byte address), wb_dat_i (in, 32, write data), wb_sel_i (in, 4, byte lanes), wb_we_i (in, 1, write), wb_stb_i (in, 1, strobe), wb_cyc_i (in, 1, cycle).
REQ-005 SHALL have ports wb_dat_o (out, 32, read data), wb_ack_o (out, 1, normal termination), wb_err_o (out, 1, error termination).
REQ-006 SHALL have ports tx_valid (out, 1), tx_data (out, 32), tx_ready (in, 1): host-to-local stream.
REQ-007 SHALL have ports rx_valid (in, 1), rx_data (in, 32), rx_ready (out, 1): local-to-host stream.
REQ-008 SHALL have port irq (out, 1, level interrupt).

Function
REQ-009 SHALL decode wb_adr_i[7:2]: 0x00 ID (RO), 0x04 STATUS, 0x08 TXDATA (WO), 0x0C RXDATA (RO), 0x10 SCRATCH (RW); other offsets terminate with wb_err_o.
REQ-010 SHALL assert exactly one of wb_ack_o/wb_err_o for one cycle, the cycle after wb_cyc_i & wb_stb_i is sampled high with no termination already asserted (1-cycle latency, no double termination).
REQ-011 SHALL err on write to ID/RXDATA, read of TXDATA, or TXDATA write with wb_sel_i != 4'hF; erroring accesses cause no state change.
REQ-012 SHALL register wb_dat_o with the termination; wb_dat_o is 0 when no read terminates.
REQ-013 SHALL push wb_dat_i into TX FIFO on an acked TXDATA write; if full, drop the data and set sticky STATUS[4] tx_overflow.
REQ-014 SHALL pop RX FIFO on an acked RXDATA read, returning head word; if empty, return 0 and set sticky STATUS[5] rx_underflow.
REQ-015 SHALL define STATUS: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] tx_overflow, [5] rx_underflow, [14:8] tx_count, [22:16] rx_count, others 0.
REQ-016 SHALL clear STATUS[4]/[5] when written with 1 in that bit (W1C, byte lane 0 only); other STATUS bits ignore writes; a same-cycle set event wins over clear.
REQ-017 SHALL apply SCRATCH writes per byte lane from wb_sel_i.
REQ-018 SHALL drive tx_valid = TX not empty, tx_data = TX head (first-word fall-through); pop when tx_valid & tx_ready.
REQ-019 SHALL drive rx_ready = RX not full; push rx_data when rx_valid & rx_ready.
REQ-020 SHALL permit simultaneous push and pop on one FIFO in one cycle, including at full (bus push blocked, since full flag gates it) and empty (stream pop blocked); count unchanged when both occur.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH; counts range 0..DEPTH.

Reset
REQ-022 SHALL on wb_rst_n low asynchronously clear: FIFOs empty (tx_valid=0, rx_ready=1), sticky flags 0, SCRATCH 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, irq=0; a bus cycle in progress is abandoned without termination.

Configuration
REQ-023 SHALL, with macro WB_SPI_MAILBOX_IRQ_EN defined, drive irq registered = (~rx_empty | tx_overflow | rx_underflow).
REQ-024 SHALL, without WB_SPI_MAILBOX_IRQ_EN, tie irq to 0; port remains present.

Structure
REQ-025 SHALL place register offset constants, STATUS bit-index constants and ID default in package wb_spi_mailbox_pkg.
REQ-026 SHALL implement both FIFOs as two instances of sub-module mbx_fifo (parameter DEPTH, push/pop/full/empty/count).

Verification
REQ-027 Reset, read 0x00 -> ack after 1 cycle, data 32'h4D42_0001; read 0x04 -> 32'h0000_000A.
REQ-028 Write 0x08 with 32'hDEAD_BEEF, tx_ready=0 -> tx_valid=1, tx_data=DEAD_BEEF, STATUS tx_count=1; raise tx_ready one cycle -> tx_valid=0.
REQ-029 DEPTH=8, 9 TXDATA writes with tx_ready=0 -> STATUS[0]=1, STATUS[4]=1, tx_count=8; write 0x04 with 0x10 -> STATUS[4]=0.
REQ-030 Read 0x0C on empty RX -> data 0, STATUS[5]=1; push 32'h1234_5678 via rx_valid -> irq=1 (IRQ_EN); read 0x0C -> 1234_5678, rx_empty=1.
REQ-031 Write 0x10 with 32'hAABB_CCDD sel=4'b0101 over 0 -> readback 32'h00BB_00DD; write 0x20 -> wb_err_o one cycle, no ack.
REQ-032 Assert wb_rst_n low mid-cycle with TX holding 3 words -> tx_valid=0, wb_ack_o=0 immediately, STATUS reads 32'h0000_000A after release.
